msrv32_ifu: RTL and testbench

MSRV32_IFU -- requirements
Module: msrv32_ifu

---
 rtl/msrv32_ifu_if.sv | 33 +++
 rtl/msrv32_ifu.sv | 142 ++++++++++++++
 tb/tb_msrv32_ifu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_ifu_if.sv
// msrv32 fetch unit signal bundle:
// instruction memory, redirect and decoder handshakes.
interface msrv32_ifu_if;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_ack_in;
   logic [31:0] imem_rdata_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        instr_valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_ready_in;
   logic        misaligned_instr_out;

   modport master (
      output imem_req_out, imem_addr_out,
      output instr_valid_out, instr_out, pc_out,
      output misaligned_instr_out,
      input  imem_ack_in, imem_rdata_in,
      input  redirect_in, redirect_pc_in,
      input  instr_ready_in
   );

   modport slave (
      input  imem_req_out, imem_addr_out,
      input  instr_valid_out, instr_out, pc_out,
      input  misaligned_instr_out,
      output imem_ack_in, imem_rdata_in,
      output redirect_in, redirect_pc_in,
      output instr_ready_in
   );
endinterface

// File: rtl/msrv32_ifu.sv
// msrv32 instruction fetch unit: one-outstanding imem
// requester feeding a 2-entry {pc, instr} FIFO.
module msrv32_ifu #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic         ms_riscv32_mp_clk_in,
   input  logic         ms_riscv32_mp_rst_in,
   msrv32_ifu_if.master bus
);
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   logic        clk;
   logic        rst;
   state_t      state;
   state_t      state_n;
   logic        halt_q;
   logic        halt_n;
   logic [31:0] fetch_pc;
   logic [31:0] req_addr_q;
   logic [31:0] addr;
   logic        pend_q;
   logic        req;
   logic        xfer;
   logic        push;
   logic        pop;
   logic        redir;
   logic        redir_ok;
   logic        redir_bad;
   logic        mis_q;
   logic [31:0] fifo_pc  [2];
   logic [31:0] fifo_ins [2];
   logic [1:0]  count;
   logic        rd_ptr;
   logic        wr_ptr;

   assign clk       = ms_riscv32_mp_clk_in;
   assign rst       = ms_riscv32_mp_rst_in;
   assign redir     = bus.redirect_in;
   assign redir_bad = redir && (bus.redirect_pc_in[1:0] != 2'b00);
   assign redir_ok  = redir && !redir_bad;
   assign xfer      = req && bus.imem_ack_in;
   assign push      = (state == FETCH) && xfer && !redir;
   assign pop       = (count != 2'd0) && bus.instr_ready_in && !redir;
   assign wr_ptr    = rd_ptr ^ count[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FETCH;
         halt_q <= 1'b0;
      end else begin
         state  <= state_n;
         halt_q <= halt_n;
      end
   end

   // halt_q remembers where DRAIN goes once the stale ack lands
   always_comb begin
      state_n = state;
      halt_n  = halt_q;
      unique case (state)
         FETCH: begin
            if (redir) begin
               halt_n = redir_bad;
               if (req && !bus.imem_ack_in)
                  state_n = DRAIN;
               else if (redir_bad)
                  state_n = HALT;
            end
         end
         DRAIN: begin
            if (redir)
               halt_n = redir_bad;
            if (xfer)
               state_n = (redir ? redir_bad : halt_q) ? HALT : FETCH;
         end
         HALT: begin
            if (redir_ok) begin
               state_n = FETCH;
               halt_n  = 1'b0;
            end
         end
         default: state_n = FETCH;
      endcase
   end

   // a pending request keeps its captured address until acked
   always_comb begin
      req  = 1'b0;
      addr = pend_q ? req_addr_q : fetch_pc;
      if (!rst) begin
         unique case (state)
            FETCH:   req = pend_q || (count != 2'd2);
            DRAIN:   req = pend_q;
            default: req = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= BOOT_ADDR;
         req_addr_q  <= 32'h0;
         pend_q      <= 1'b0;
         mis_q       <= 1'b0;
         count       <= 2'd0;
         rd_ptr      <= 1'b0;
         fifo_pc[0]  <= 32'h0;
         fifo_pc[1]  <= 32'h0;
         fifo_ins[0] <= 32'h0;
         fifo_ins[1] <= 32'h0;
      end else begin
         pend_q     <= req && !bus.imem_ack_in;
         req_addr_q <= addr;
         mis_q      <= redir_bad;
         if (redir_ok)
            fetch_pc <= bus.redirect_pc_in;
         else if (push)
            fetch_pc <= fetch_pc + 32'd4;
         if (push) begin
            fifo_pc[wr_ptr]  <= addr;
            fifo_ins[wr_ptr] <= bus.imem_rdata_in;
         end
         if (redir)
            count <= 2'd0;
         else
            count <= count + {1'b0, push} - {1'b0, pop};
         if (pop)
            rd_ptr <= ~rd_ptr;
      end
   end

   assign bus.imem_req_out         = req;
   assign bus.imem_addr_out        = addr;
   assign bus.instr_valid_out      = (count != 2'd0);
   assign bus.instr_out            = fifo_ins[rd_ptr];
   assign bus.pc_out               = fifo_pc[rd_ptr];
   assign bus.misaligned_instr_out = mis_q;
endmodule

// File: tb/tb_msrv32_ifu.sv
// Randomized scoreboard bench for msrv32_ifu:
// memory responder + program-order fetch model.
module tb_msrv32_ifu;
   localparam logic [31:0] BOOT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   msrv32_ifu_if bus ();

   msrv32_ifu #(.BOOT_ADDR(BOOT)) dut (
      .ms_riscv32_mp_clk_in(clk),
      .ms_riscv32_mp_rst_in(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          pops = 0;
   ent_t        exp_q[$];
   ent_t        stage_q[$];
   logic        exp_mis = 1'b0;
   logic [31:0] fetch_ptr = BOOT;
   logic [31:0] held_addr = 32'h0;
   int          epoch = 0;
   int          req_epoch = 0;
   bit          outstanding = 1'b0;
   bit          halted = 1'b0;
   int          p_ack = 100;
   int          p_rdy = 100;
   int          p_redir = 0;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
         t = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1)) * 32'd4;
      end else if (r <= 2) begin
         t = $urandom;
         t[1:0] = 2'($urandom_range(1, 3));
      end else begin
         t = $urandom & 32'h0000_FFFC;
      end
      return t;
   endfunction

   task automatic model_reset();
      fetch_ptr   = BOOT;
      outstanding = 1'b0;
      halted      = 1'b0;
      epoch++;
      stage_q.delete();
   endtask

   task automatic step();
      logic        req;
      logic [31:0] a;
      logic [31:0] tgt;
      bit          ack;
      bit          rdy;
      bit          rdr;
      int          occ;
      req = bus.imem_req_out;
      a   = bus.imem_addr_out;
      occ = exp_q.size();
      chk("imem_req", 32'(req), 32'(outstanding || (!halted && occ < 2)));
      if (req)
         chk(outstanding ? "addr_hold" : "addr_fetch", a,
             outstanding ? held_addr : fetch_ptr);
      ack = $urandom_range(0, 99) < p_ack;
      rdy = $urandom_range(0, 99) < p_rdy;
      rdr = force_redir ||
            ($urandom_range(0, 99) < (halted ? 20 : p_redir));
      tgt = force_redir ? force_pc : pick_target();
      force_redir = 1'b0;
      bus.imem_ack_in    = ack;
      bus.imem_rdata_in  = req ? memf(a) : $urandom;
      bus.instr_ready_in = rdy;
      bus.redirect_in    = rdr;
      bus.redirect_pc_in = rdr ? tgt : $urandom;
      if (req && !outstanding) begin
         req_epoch = epoch;
         held_addr = a;
      end
      if (req && ack) begin
         if (!rdr && req_epoch == epoch && !halted) begin
            stage_q.push_back('{pc: a, ins: memf(a)});
            fetch_ptr = fetch_ptr + 32'd4;
         end
         outstanding = 1'b0;
      end else begin
         outstanding = req;
      end
      if (rdr) begin
         epoch++;
         if (tgt[1:0] == 2'b00) begin
            fetch_ptr = tgt;
            halted    = 1'b0;
         end else begin
            halted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.redirect_in = 1'b0;
      repeat (n) begin
         bus.imem_ack_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      model_reset();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_req", 32'(bus.imem_req_out), 32'h0);
            chk("rst_valid", 32'(bus.instr_valid_out), 32'h0);
            chk("rst_mis", 32'(bus.misaligned_instr_out), 32'h0);
            chk("rst_instr", bus.instr_out, 32'h0);
            chk("rst_pc", bus.pc_out, 32'h0);
            exp_q.delete();
            exp_mis = 1'b0;
         end else begin
            chk("misaligned", 32'(bus.misaligned_instr_out), 32'(exp_mis));
            exp_mis = bus.redirect_in && (bus.redirect_pc_in[1:0] != 2'b00);
            chk("valid", 32'(bus.instr_valid_out), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               chk("pc_out", bus.pc_out, exp_q[0].pc);
               chk("instr_out", bus.instr_out, exp_q[0].ins);
            end
            if (bus.redirect_in) begin
               exp_q.delete();
            end else if (bus.instr_valid_out && bus.instr_ready_in &&
                         exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               pops++;
            end
            while (stage_q.size() != 0)
               exp_q.push_back(stage_q.pop_front());
         end
      end
   end

   initial begin
      bus.imem_ack_in    = 1'b0;
      bus.imem_rdata_in  = 32'h0;
      bus.redirect_in    = 1'b0;
      bus.redirect_pc_in = 32'h0;
      bus.instr_ready_in = 1'b0;
      #1;
      do_reset(3);
      p_ack = 100; p_rdy = 100; p_redir = 0;
      repeat (12) step();
      p_rdy = 0;
      repeat (6) step();
      p_rdy = 100;
      repeat (6) step();
      force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
      repeat (8) step();
      force_redir = 1'b1; force_pc = 32'h0000_0102;
      repeat (4) step();
      force_redir = 1'b1; force_pc = 32'h0000_0200;
      repeat (8) step();
      p_ack = 60; p_rdy = 60; p_redir = 5;
      repeat (3000) step();
      do_reset(2);
      repeat (200) step();
      p_ack = 50; p_rdy = 70; p_redir = 30;
      repeat (500) step();
      chk("progress", 32'(pops > 200), 32'h1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
